// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared IF/ID operation codes, defaults and fetch entry type
package if_pkg;

  localparam logic [1:0] IFID_ADV    = 2'd0;
  localparam logic [1:0] IFID_BUBBLE = 2'd1;
  localparam logic [1:0] IFID_HOLD   = 2'd2;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Reference 32-bit layout of a queued fetch; wider builds use the same field order
  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// rtl/if_prefetch_stage_if.sv - control, instruction memory and IF/ID signal bundle
interface if_prefetch_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            stall_fetch;
  logic [1:0]      ifid_op;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] id_pc_plus_4;
  logic [XLEN-1:0] id_instr;
  logic            id_valid;
  logic [CW-1:0]   q_count;

  // Fetch stage side
  modport master (
    input  stall_fetch, ifid_op, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, id_pc_plus_4, id_instr, id_valid, q_count
  );

  // Pipeline / memory side
  modport slave (
    output stall_fetch, ifid_op, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, id_pc_plus_4, id_instr, id_valid, q_count
  );
endinterface

// File: rtl/if_prefetch_stage_fetch_fifo.sv
// rtl/if_prefetch_stage_fetch_fifo.sv - synchronous FIFO holding prefetched instructions
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Pointer and occupancy update; clear discards everything, pointers wrap naturally (power-of-two depth)
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage itself needs no reset since occupancy guards every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) (pop && !clear) |-> !empty);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) (push && full && !clear) |-> pop);

endmodule

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - instruction fetch stage with prefetch queue and redirect
import if_pkg::*;

module if_prefetch_stage #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input logic                  clk,
  input logic                  reset,
  if_prefetch_stage_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] id_pc_plus_4_q, id_pc_plus_4_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;

  logic            q_full, q_empty, q_push, q_pop, fetch, bypass;
  logic [CW-1:0]   q_count;
  entry_t          fetched, head;
  logic [2*XLEN-1:0] head_raw;

  assign fetched = '{pc_plus_4: pc_q + XLEN'(4), instr: bus.imem_rdata};
  assign head    = entry_t'(head_raw);

  // Fetch/queue control: redirect suppresses everything, a full queue fetches only while draining
  always_comb begin
    q_pop  = (bus.ifid_op == IFID_ADV) && !q_empty && !bus.redirect_valid;
    fetch  = !reset && !bus.redirect_valid && !bus.stall_fetch && (!q_full || q_pop);
    bypass = fetch && q_empty && (bus.ifid_op == IFID_ADV);
    q_push = fetch && !bypass;
  end

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (bus.redirect_valid),
    .wdata (fetched),
    .rdata (head_raw),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Next PC and IF/ID contents; redirect outranks stall and decode hold
  always_comb begin
    pc_d           = pc_q;
    id_pc_plus_4_d = id_pc_plus_4_q;
    id_instr_d     = id_instr_q;
    id_valid_d     = id_valid_q;
    if (bus.redirect_valid) begin
      pc_d           = {bus.redirect_pc[XLEN-1:2], 2'b00};
      id_pc_plus_4_d = '0;
      id_instr_d     = NOP_INSTR;
      id_valid_d     = 1'b0;
    end else begin
      if (fetch) begin
        pc_d = fetched.pc_plus_4;
      end
      case (bus.ifid_op)
        IFID_ADV: begin
          if (q_pop) begin
            id_pc_plus_4_d = head.pc_plus_4;
            id_instr_d     = head.instr;
            id_valid_d     = 1'b1;
          end else if (bypass) begin
            id_pc_plus_4_d = fetched.pc_plus_4;
            id_instr_d     = fetched.instr;
            id_valid_d     = 1'b1;
          end else begin
            id_pc_plus_4_d = '0;
            id_instr_d     = NOP_INSTR;
            id_valid_d     = 1'b0;
          end
        end
        IFID_BUBBLE: begin
          id_pc_plus_4_d = '0;
          id_instr_d     = NOP_INSTR;
          id_valid_d     = 1'b0;
        end
        IFID_HOLD, 2'd3: begin
          id_pc_plus_4_d = id_pc_plus_4_q;
        end
        default: begin
          id_valid_d = id_valid_q;
        end
      endcase
    end
  end

  // PC and IF/ID register; reset clears the IF/ID word to zero, not to NOP_INSTR
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      id_pc_plus_4_q <= '0;
      id_instr_q     <= '0;
      id_valid_q     <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      id_pc_plus_4_q <= id_pc_plus_4_d;
      id_instr_q     <= id_instr_d;
      id_valid_q     <= id_valid_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.id_pc_plus_4 = id_pc_plus_4_q;
  assign bus.id_instr     = id_instr_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.q_count      = q_count;

endmodule
